// File: rtl/alu_wb_stage_if.sv
// Shared result type and the handshake/redirect interface for alu_wb_stage.
// The package sits here so the interface, the stage and the bench all see one definition.
package alu_wb_pkg;
  localparam int unsigned VADDR_WIDTH  = 32;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned AL_IDX_WIDTH = 5;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpLui, OpSlt,
    OpJal, OpJalr, OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu
  } alu_op_e;

  typedef logic [AL_IDX_WIDTH-1:0] al_idx_t;

  typedef struct packed {
    logic                   valid;
    alu_op_e                op;
    al_idx_t                al_idx;
    logic [VADDR_WIDTH-1:0] op_addr;
    logic [XLEN-1:0]        rd_val;
    logic                   actual_taken;
    logic [VADDR_WIDTH-1:0] actual_taken_addr;
  } vuop_result_t;
endpackage

interface alu_wb_if;
  import alu_wb_pkg::*;

  vuop_result_t           res_in;
  logic                   pred_taken;
  logic [VADDR_WIDTH-1:0] pred_addr;
  logic                   in_ready;
  vuop_result_t           wb_out;
  logic                   wb_ready;
  logic                   flush;
  logic                   redirect_valid;
  logic [VADDR_WIDTH-1:0] redirect_addr;
  al_idx_t                redirect_al_idx;

  modport master (
    output res_in, pred_taken, pred_addr, wb_ready, flush,
    input  in_ready, wb_out, redirect_valid, redirect_addr, redirect_al_idx
  );

  modport slave (
    input  res_in, pred_taken, pred_addr, wb_ready, flush,
    output in_ready, wb_out, redirect_valid, redirect_addr, redirect_al_idx
  );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: result FIFO toward the ROB plus registered mispredict redirect.
// Optional perf counters (branch_cnt, mispred_cnt) are built when ALU_WB_PERF_EN is defined.
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_wb_if.slave              bus
`ifdef ALU_WB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  vuop_result_t           mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   redirect_valid_q;
  logic [VADDR_WIDTH-1:0] redirect_addr_q;
  al_idx_t                redirect_al_idx_q;

  logic                   in_ready, push, pop, is_cf, mispred;
  logic [VADDR_WIDTH-1:0] correct_pc;
  vuop_result_t           head;

  assign in_ready = (count_q != FullCnt);
  assign push     = bus.res_in.valid & in_ready & ~bus.flush;
  assign pop      = (count_q != '0) & bus.wb_ready;

  always_comb begin
    is_cf = 1'b0;
    unique case (bus.res_in.op)
      OpJal, OpJalr, OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: is_cf = 1'b1;
      default: is_cf = 1'b0;
    endcase
  end

  assign mispred = is_cf &
      ((bus.res_in.actual_taken != bus.pred_taken) |
       (bus.res_in.actual_taken & (bus.res_in.actual_taken_addr != bus.pred_addr)));

  assign correct_pc = bus.res_in.actual_taken ? bus.res_in.actual_taken_addr
                                              : bus.res_in.op_addr + VADDR_WIDTH'(4);

  // Stored entries keep valid=1; the presented valid comes from occupancy.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head.valid = (count_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_addr_q   <= '0;
      redirect_al_idx_q <= '0;
    end else if (bus.flush) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.res_in;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
      redirect_valid_q <= push & mispred;
      if (push && mispred) begin
        redirect_addr_q   <= correct_pc;
        redirect_al_idx_q <= bus.res_in.al_idx;
      end
    end
  end

`ifdef ALU_WB_PERF_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q, mispred_cnt_q;

  // push already excludes flush cycles, so flush needs no special handling here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (push && is_cf && branch_cnt_q != '1)   branch_cnt_q  <= branch_cnt_q + CNT_WIDTH'(1);
      if (push && mispred && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

  assign bus.in_ready        = in_ready;
  assign bus.wb_out          = head;
  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_addr   = redirect_addr_q;
  assign bus.redirect_al_idx = redirect_al_idx_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_wb_stage;
  import alu_wb_pkg::*;

  localparam int DEPTH = 2;

  logic clk, rst;
  alu_wb_if bus ();

`ifdef ALU_WB_PERF_EN
  logic [31:0] branch_cnt, mispred_cnt;
`endif

  alu_wb_stage #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef ALU_WB_PERF_EN
    ,
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  vuop_result_t mq[$];
  logic         exp_rv;
  logic [31:0]  exp_ra;
  al_idx_t      exp_ri;
  int           exp_bc, exp_mc;

  function automatic vuop_result_t mk(alu_op_e op, logic [31:0] addr, logic [31:0] rd,
                                      logic taken, logic [31:0] tgt, al_idx_t idx);
    vuop_result_t r;
    r.valid = 1'b1; r.op = op; r.al_idx = idx; r.op_addr = addr; r.rd_val = rd;
    r.actual_taken = taken; r.actual_taken_addr = tgt;
    return r;
  endfunction

  function automatic logic ctrl_flow(alu_op_e op);
    return op inside {OpJal, OpJalr, OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu};
  endfunction

  task automatic idle_inputs();
    bus.res_in = '0; bus.pred_taken = 1'b0; bus.pred_addr = '0;
    bus.wb_ready = 1'b0; bus.flush = 1'b0;
  endtask

  // Advance the model by the inputs currently driven, then clock the DUT.
  task automatic step();
    logic push, pop, mp;
    vuop_result_t r;
    r    = bus.res_in;
    push = r.valid && (mq.size() < DEPTH) && !bus.flush;
    pop  = (mq.size() > 0) && bus.wb_ready;
    mp   = ctrl_flow(r.op) && ((r.actual_taken != bus.pred_taken) ||
           (r.actual_taken && (r.actual_taken_addr != bus.pred_addr)));
    if (bus.flush) begin
      mq.delete();
      exp_rv = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(r);
      exp_rv = push && mp;
      if (push && mp) begin
        exp_ra = r.actual_taken ? r.actual_taken_addr : r.op_addr + 32'd4;
        exp_ri = r.al_idx;
      end
      if (push && ctrl_flow(r.op)) exp_bc++;
      if (push && mp) exp_mc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    mq.delete();
    exp_rv = 1'b0; exp_ra = '0; exp_ri = '0; exp_bc = 0; exp_mc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    n_tests++; if (bus.wb_out !== '0) begin n_fail++;
      $display("FAIL reset_wb_out got=%h want=0", bus.wb_out); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_redirect_valid got=%b want=0", bus.redirect_valid); end
    n_tests++; if (bus.redirect_addr !== 32'h0 || bus.redirect_al_idx !== '0) begin n_fail++;
      $display("FAIL reset_redirect_fields got=%h/%h want=0/0",
               bus.redirect_addr, bus.redirect_al_idx); end
  endtask

  task automatic test_basic();
    bus.wb_ready = 1'b1;
    bus.res_in = mk(OpAdd, 32'h100, 32'h5, 1'b0, 32'h0, 5'd1);
    step();
    bus.res_in = '0;
    n_tests++; if (bus.wb_out.valid !== 1'b1 || bus.wb_out.rd_val !== 32'h5) begin n_fail++;
      $display("FAIL basic_wb_out got v=%b rd=%h want v=1 rd=5",
               bus.wb_out.valid, bus.wb_out.rd_val); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++;
      $display("FAIL basic_no_redirect got=%b want=0", bus.redirect_valid); end
    step();
    n_tests++; if (bus.wb_out.valid !== 1'b0) begin n_fail++;
      $display("FAIL basic_drained got=%b want=0", bus.wb_out.valid); end
  endtask

  task automatic test_backpressure();
    vuop_result_t a, b, c;
    a = mk(OpAdd, 32'h10, 32'hA, 1'b0, 32'h0, 5'd2);
    b = mk(OpSub, 32'h14, 32'hB, 1'b0, 32'h0, 5'd3);
    c = mk(OpXor, 32'h18, 32'hC, 1'b0, 32'h0, 5'd4);
    bus.wb_ready = 1'b0;
    bus.res_in = a; step();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_ready_after_1 got=%b want=1", bus.in_ready); end
    bus.res_in = b; step();
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_full got=%b want=0", bus.in_ready); end
    bus.res_in = c; step();
    n_tests++; if (bus.wb_out !== a || bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_held_head got=%h rdy=%b want=%h rdy=0", bus.wb_out, bus.in_ready, a); end
    bus.res_in = '0; bus.wb_ready = 1'b1; step();
    n_tests++; if (bus.wb_out !== b) begin n_fail++;
      $display("FAIL bp_second got=%h want=%h", bus.wb_out, b); end
    step();
    n_tests++; if (bus.wb_out.valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_empty got=%b want=0 (third op must not appear)", bus.wb_out.valid); end
  endtask

  task automatic test_mispredict();
    bus.wb_ready = 1'b1;
    bus.res_in = mk(OpBeq, 32'h1000, 32'h0, 1'b1, 32'h1040, 5'd7);
    bus.pred_taken = 1'b0; bus.pred_addr = 32'h0;
    step();
    bus.res_in = '0;
    n_tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h1040 ||
        bus.redirect_al_idx !== 5'd7) begin n_fail++;
      $display("FAIL beq_redirect got v=%b a=%h i=%0d want v=1 a=1040 i=7",
               bus.redirect_valid, bus.redirect_addr, bus.redirect_al_idx); end
    step();
    n_tests++; if (bus.redirect_valid !== 1'b0 || bus.redirect_addr !== 32'h1040) begin n_fail++;
      $display("FAIL beq_one_cycle got v=%b a=%h want v=0 a=1040",
               bus.redirect_valid, bus.redirect_addr); end
    bus.res_in = mk(OpBne, 32'h2000, 32'h0, 1'b0, 32'h2abc, 5'd3);
    bus.pred_taken = 1'b1; bus.pred_addr = 32'h2abc;
    step();
    n_tests++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h2004 ||
        bus.redirect_al_idx !== 5'd3) begin n_fail++;
      $display("FAIL bne_redirect got v=%b a=%h i=%0d want v=1 a=2004 i=3",
               bus.redirect_valid, bus.redirect_addr, bus.redirect_al_idx); end
    bus.res_in = mk(OpJal, 32'h2100, 32'h2104, 1'b1, 32'h3000, 5'd9);
    bus.pred_taken = 1'b1; bus.pred_addr = 32'h3000;
    step();
    bus.res_in = '0;
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++;
      $display("FAIL jal_correct got=%b want=0", bus.redirect_valid); end
    bus.res_in = mk(OpJalr, 32'h2200, 32'h0, 1'b1, 32'h4000, 5'd11);
    bus.pred_taken = 1'b1; bus.pred_addr = 32'h4008;
    step();
    bus.res_in = '0;
    n_tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h4000) begin n_fail++;
      $display("FAIL jalr_wrong_target got v=%b a=%h want v=1 a=4000",
               bus.redirect_valid, bus.redirect_addr); end
    step();
  endtask

  task automatic test_flush();
    bus.wb_ready = 1'b0; bus.pred_taken = 1'b0; bus.pred_addr = '0;
    bus.res_in = mk(OpAdd, 32'h50, 32'h1, 1'b0, 32'h0, 5'd1); step();
    bus.res_in = mk(OpOr,  32'h54, 32'h2, 1'b0, 32'h0, 5'd2); step();
    bus.res_in = mk(OpBlt, 32'h58, 32'h0, 1'b1, 32'h80, 5'd3);
    bus.flush = 1'b1; bus.wb_ready = 1'b1;
    step();
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
    n_tests++;
    if (bus.wb_out.valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.redirect_valid !== 1'b0)
    begin n_fail++;
      $display("FAIL flush_full got v=%b rdy=%b rv=%b want 0/1/0",
               bus.wb_out.valid, bus.in_ready, bus.redirect_valid); end
    // Non-full FIFO: the mispredicting op would otherwise be accepted.
    bus.res_in = mk(OpAdd, 32'h60, 32'h3, 1'b0, 32'h0, 5'd4); step();
    bus.res_in = mk(OpBge, 32'h64, 32'h0, 1'b1, 32'h90, 5'd5); bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    n_tests++; if (bus.wb_out.valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_drop got v=%b rv=%b want 0/0", bus.wb_out.valid, bus.redirect_valid);
    end
    bus.res_in = mk(OpSll, 32'h68, 32'h77, 1'b0, 32'h0, 5'd6); step();
    bus.res_in = '0;
    n_tests++; if (bus.wb_out !== mk(OpSll, 32'h68, 32'h77, 1'b0, 32'h0, 5'd6)) begin n_fail++;
      $display("FAIL flush_resume got=%h", bus.wb_out); end
    bus.wb_ready = 1'b1; step();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      vuop_result_t r;
      r.valid             = ($urandom_range(0, 3) != 0);
      r.op                = alu_op_e'($urandom_range(0, 15));
      r.al_idx            = al_idx_t'($urandom);
      r.op_addr           = $urandom & 32'hffff_fffc;
      r.rd_val            = $urandom;
      r.actual_taken      = $urandom_range(0, 1) == 1;
      r.actual_taken_addr = $urandom & 32'hffff_fffc;
      bus.res_in     = r;
      bus.pred_taken = $urandom_range(0, 1) == 1;
      bus.pred_addr  = ($urandom_range(0, 1) == 1) ? r.actual_taken_addr : $urandom;
      bus.wb_ready   = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      step();
      n_tests++;
      if (bus.in_ready !== (mq.size() < DEPTH) || bus.wb_out.valid !== (mq.size() > 0) ||
          (mq.size() > 0 && bus.wb_out !== mq[0]) || bus.redirect_valid !== exp_rv ||
          bus.redirect_addr !== exp_ra || bus.redirect_al_idx !== exp_ri) begin
        n_fail++;
        if (errs++ < 5)
          $display("FAIL rand_cyc%0d got rdy=%b wb=%h rv=%b ra=%h ri=%0d want sz=%0d rv=%b ra=%h ri=%0d",
                   cyc, bus.in_ready, bus.wb_out, bus.redirect_valid, bus.redirect_addr,
                   bus.redirect_al_idx, mq.size(), exp_rv, exp_ra, exp_ri);
      end
`ifdef ALU_WB_PERF_EN
      n_tests++;
      if (branch_cnt !== 32'(exp_bc) || mispred_cnt !== 32'(exp_mc)) begin
        n_fail++;
        if (errs++ < 5)
          $display("FAIL rand_cnt_cyc%0d got %0d/%0d want %0d/%0d",
                   cyc, branch_cnt, mispred_cnt, exp_bc, exp_mc);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.wb_ready = 1'b0;
    bus.res_in = mk(OpBltu, 32'h700, 32'h0, 1'b1, 32'h7f0, 5'd12);
    bus.pred_taken = 1'b0;
    step();
    bus.res_in = '0;
    n_tests++; if (bus.redirect_valid !== 1'b1 || bus.wb_out.valid !== 1'b1) begin n_fail++;
      $display("FAIL arst_pre got rv=%b v=%b want 1/1", bus.redirect_valid, bus.wb_out.valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.redirect_valid !== 1'b0 || bus.wb_out !== '0 || bus.in_ready !== 1'b1 ||
        bus.redirect_addr !== 32'h0 || bus.redirect_al_idx !== '0) begin n_fail++;
      $display("FAIL arst_immediate got rv=%b wb=%h rdy=%b ra=%h ri=%0d want all reset",
               bus.redirect_valid, bus.wb_out, bus.in_ready, bus.redirect_addr,
               bus.redirect_al_idx); end
    do_reset();
  endtask

`ifdef ALU_WB_PERF_EN
  task automatic test_perf();
    do_reset();
    bus.wb_ready = 1'b1;
    bus.res_in = mk(OpBeq, 32'h10, 0, 1'b0, 32'h40, 5'd1); bus.pred_taken = 1'b0; step();
    bus.res_in = mk(OpJal, 32'h14, 0, 1'b1, 32'h80, 5'd2);
    bus.pred_taken = 1'b1; bus.pred_addr = 32'h80; step();
    bus.res_in = mk(OpAdd, 32'h18, 0, 1'b0, 32'h0, 5'd3); step();
    bus.res_in = mk(OpBne, 32'h1c, 0, 1'b1, 32'hc0, 5'd4); bus.pred_taken = 1'b0; step();
    bus.res_in = mk(OpBgeu, 32'h20, 0, 1'b0, 32'h0, 5'd5); step();
    bus.res_in = '0; step();
    n_tests++; if (branch_cnt !== 32'd4 || mispred_cnt !== 32'd1) begin n_fail++;
      $display("FAIL perf_counts got %0d/%0d want 4/1", branch_cnt, mispred_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_mispredict();
    test_flush();
    test_random();
    test_async_reset();
`ifdef ALU_WB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
